// File: rtl/fnd_pkg.sv
// Shared constants, FSM state type and helpers for the scanned FND adder.
// Optional feature macro: FND_LZB_EN (leading-zero blanking, used in fnd_adder_scan).
package fnd_pkg;

    // Active-low segment codes {dp,g,f,e,d,c,b,a}; dp is always off.
    localparam logic [7:0] FONT_0     = 8'hC0;
    localparam logic [7:0] FONT_1     = 8'hF9;
    localparam logic [7:0] FONT_2     = 8'hA4;
    localparam logic [7:0] FONT_3     = 8'hB0;
    localparam logic [7:0] FONT_4     = 8'h99;
    localparam logic [7:0] FONT_5     = 8'h92;
    localparam logic [7:0] FONT_6     = 8'h82;
    localparam logic [7:0] FONT_7     = 8'hF8;
    localparam logic [7:0] FONT_8     = 8'h80;
    localparam logic [7:0] FONT_9     = 8'h90;
    localparam logic [7:0] FONT_DASH  = 8'hBF;
    localparam logic [7:0] FONT_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    // Decimal digits needed for the largest unsigned value of the given bit width.
    function automatic int dec_digits(input int bits);
        longint unsigned v;
        int d;
        v = (64'd1 << bits) - 64'd1;
        d = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            d++;
        end
        return d;
    endfunction

    function automatic logic [7:0] font_of(input logic [3:0] n);
        case (n)
            4'd0:    return FONT_0;
            4'd1:    return FONT_1;
            4'd2:    return FONT_2;
            4'd3:    return FONT_3;
            4'd4:    return FONT_4;
            4'd5:    return FONT_5;
            4'd6:    return FONT_6;
            4'd7:    return FONT_7;
            4'd8:    return FONT_8;
            4'd9:    return FONT_9;
            default: return FONT_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/fnd_adder_scan_if.sv
// Link between the sum stage (master) and the sequential binary-to-BCD converter (slave).
interface fnd_adder_scan_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 4
) ();
    import fnd_pkg::*;

    // start is a level request, held while bin differs from src; the converter
    // accepts it only in IDLE, snapshots bin into src, and the request drops by itself.
    logic                  start;
    logic [WIDTH:0]        bin;
    logic [WIDTH:0]        src;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;
    logic                  done;
    logic                  busy;
    conv_state_t           state;

    modport master (output start, bin, input src, bcd, overflow, done, busy, state);
    modport slave  (input start, bin, output src, bcd, overflow, done, busy, state);

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, WIDTH+1 steps, then a
// single DONE cycle that publishes the digits and the overflow flag.
module bin2bcd_seq
    import fnd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    fnd_adder_scan_if.slave     bus
);

    localparam int NB_BIN = dec_digits(WIDTH + 1);
    localparam int NB     = (NB_BIN > DIGITS) ? NB_BIN : DIGITS;
    localparam int CW     = $clog2(WIDTH + 2);
    localparam longint unsigned LIMIT = pow10(DIGITS) - 64'd1;

    conv_state_t          r_state, w_state_nx;
    logic [WIDTH:0]       r_src, r_sh, w_sh_nx;
    logic [4*NB-1:0]      r_bcd, w_adj, w_bcd_nx;
    logic [CW-1:0]        r_cnt;
    logic [4*DIGITS-1:0]  r_disp;
    logic                 r_ovf;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_state_nx = ST_SHIFT;
            ST_SHIFT: if (r_cnt == CW'(WIDTH)) w_state_nx = ST_DONE;
            ST_DONE:  w_state_nx = ST_IDLE;
            default:  w_state_nx = ST_IDLE;
        endcase
    end

    // Adjust every nibble >= 5 by +3, then shift the whole {bcd, bin} word left.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < NB; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
        {w_bcd_nx, w_sh_nx} = {w_adj, r_sh} << 1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_src  <= '0;
            r_sh   <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_disp <= '0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_src <= bus.bin;
                        r_sh  <= bus.bin;
                        r_bcd <= '0;
                        r_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_bcd <= w_bcd_nx;
                    r_sh  <= w_sh_nx;
                    r_cnt <= r_cnt + CW'(1);
                end
                ST_DONE: begin
                    r_disp <= r_bcd[4*DIGITS-1:0];
                    r_ovf  <= (64'(r_src) > LIMIT);
                end
                default: ;
            endcase
        end
    end

    assign bus.src      = r_src;
    assign bus.bcd      = r_disp;
    assign bus.overflow = r_ovf;
    assign bus.busy     = (r_state == ST_SHIFT);
    assign bus.done     = (r_state == ST_DONE);
    assign bus.state    = r_state;

endmodule

// File: rtl/fnd_adder_scan.sv
// N-bit adder driving a time-multiplexed DIGITS-wide FND display.
// Define FND_LZB_EN to blank leading zeros (the ones digit always stays lit).
module fnd_adder_scan
    import fnd_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 100000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [WIDTH-1:0]  i_A,
    input  logic [WIDTH-1:0]  i_B,
    input  logic              i_Cin,
    input  logic              i_EN,
    output logic [DIGITS-1:0] o_FND_Digit,
    output logic [7:0]        o_FND_Font,
    output logic              o_busy,
    output logic              o_overflow
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    fnd_adder_scan_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    logic [WIDTH:0]      r_sum;
    logic [CW-1:0]       r_cnt;
    logic [IW-1:0]       r_idx;
    logic [DIGITS-1:0]   r_digit;
    logic [7:0]          r_font;
    logic [3:0]          w_nib;
    logic [7:0]          w_font;
    logic                w_unused;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_sum <= '0;
        else         r_sum <= {1'b0, i_A} + {1'b0, i_B} + {{WIDTH{1'b0}}, i_Cin};
    end

    assign bus.start = (r_sum != bus.src);
    assign bus.bin   = r_sum;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_conv (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

`ifdef FND_LZB_EN
    logic [DIGITS-1:0] w_blank;
    logic              w_hi_zero;

    // A digit is blank when it and every digit above it are zero, except the ones digit.
    always_comb begin
        w_hi_zero = 1'b1;
        w_blank   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_hi_zero  = w_hi_zero && (bus.bcd[4*i +: 4] == 4'd0);
            w_blank[i] = w_hi_zero && (i != 0);
        end
    end
`endif

    always_comb begin
        w_nib = bus.bcd[{r_idx, 2'b00} +: 4];
        if (bus.overflow) w_font = FONT_DASH;
        else              w_font = font_of(w_nib);
`ifdef FND_LZB_EN
        if (!bus.overflow && w_blank[r_idx]) w_font = FONT_BLANK;
`endif
    end

    // Select and font are registered together so both change on the same edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_digit <= '1;
            r_font  <= FONT_BLANK;
        end else if (!i_EN) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_digit <= '1;
            r_font  <= FONT_BLANK;
        end else begin
            if (r_cnt == CW'(SCAN_DIV - 1)) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_digit <= ~(DIGITS'(1) << r_idx);
            r_font  <= w_font;
        end
    end

    assign o_FND_Digit = r_digit;
    assign o_FND_Font  = r_font;
    assign o_busy      = bus.busy;
    assign o_overflow  = bus.overflow;
    assign w_unused    = &{1'b0, bus.done, bus.state};

endmodule

// File: tb/tb_fnd_adder_scan.sv
// Directed bench for fnd_adder_scan: a 4-digit and a 2-digit instance share stimulus.
module tb_fnd_adder_scan;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int D2 = 2;
    localparam int SD = 4;

    logic clk = 1'b0;
    logic rst;
    logic [W-1:0] a, b;
    logic cin, en;

    logic [D-1:0]  dig1;
    logic [7:0]    font1;
    logic          busy1, ovf1;
    logic [D2-1:0] dig2;
    logic [7:0]    font2;
    logic          busy2, ovf2;

    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q[$];
    logic [7:0] font_tab[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    fnd_adder_scan #(.WIDTH(W), .DIGITS(D), .SCAN_DIV(SD)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_A(a), .i_B(b), .i_Cin(cin), .i_EN(en),
        .o_FND_Digit(dig1), .o_FND_Font(font1), .o_busy(busy1), .o_overflow(ovf1)
    );

    fnd_adder_scan #(.WIDTH(W), .DIGITS(D2), .SCAN_DIV(SD)) u_dut2 (
        .i_clk(clk), .i_reset(rst), .i_A(a), .i_B(b), .i_Cin(cin), .i_EN(en),
        .o_FND_Digit(dig2), .o_FND_Font(font2), .o_busy(busy2), .o_overflow(ovf2)
    );

    // ---------------- model / checker ----------------
    function automatic logic [7:0] exp_font(input int val, input int d, input int nd);
        int lim;
        int dv;
        int nib;
        lim = 1;
        dv  = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        for (int i = 0; i < d; i++) dv = dv * 10;
        if (val >= lim) return 8'hBF;
        nib = (val / dv) % 10;
`ifdef FND_LZB_EN
        if (d > 0 && val < dv) return 8'hFF;
`endif
        return font_tab[nib];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dig1"}, dig1, 4'hF);
        chk({tag, "_font1"}, font1, 8'hFF);
        chk({tag, "_busy1"}, busy1, 1'b0);
        chk({tag, "_ovf1"}, ovf1, 1'b0);
        chk({tag, "_dig2"}, dig2, 2'h3);
        chk({tag, "_font2"}, font2, 8'hFF);
    endtask

    task automatic check_active(input string tag, input int val, input int nd,
                                input logic [7:0] digs, input logic [7:0] fnt, output int idx);
        int n;
        n   = 0;
        idx = 0;
        for (int i = 0; i < nd; i++) begin
            if (!digs[i]) begin
                n++;
                idx = i;
            end
        end
        chk({tag, "_onehot"}, n, 1);
        chk({tag, "_font"}, fnt, exp_font(val, idx, nd));
    endtask

    // One full 4-digit scan period: fonts, one-hot select and dwell per digit.
    task automatic scan_check(input int val);
        int cnt1[D];
        int cnt2[D2];
        int ix;
        cnt1 = '{default: 0};
        cnt2 = '{default: 0};
        chk("ovf_d4", ovf1, (val > 9999) ? 1 : 0);
        chk("ovf_d2", ovf2, (val > 99) ? 1 : 0);
        repeat (D * SD) begin
            check_active("scan_d4", val, D, {4'hF, dig1}, font1, ix);
            cnt1[ix]++;
            check_active("scan_d2", val, D2, {6'h3F, dig2}, font2, ix);
            cnt2[ix]++;
            @(negedge clk);
        end
        for (int i = 0; i < D; i++) chk("dwell_d4", cnt1[i], SD);
        for (int i = 0; i < D2; i++) chk("dwell_d2", cnt2[i], D * SD / D2);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input int na, input int nb, input int nc);
        a   = na[W-1:0];
        b   = nb[W-1:0];
        cin = nc[0];
        exp_q.push_back((W+1)'(na + nb + nc));
    endtask

    // Waits for a conversion; optionally changes A after change_at busy cycles.
    task automatic wait_done(input int change_at, input int new_a);
        int t;
        int len;
        t   = 0;
        len = 0;
        while (!busy1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("busy_rise", busy1, 1'b1);
        while (busy1 && len < 40) begin
            len++;
            if (len == change_at) begin
                a = new_a[W-1:0];
                exp_q.push_back((W+1)'(new_a + int'(b) + int'(cin)));
            end
            @(negedge clk);
        end
        chk("busy_len", len, W + 1);
        chk("busy_d2", busy2, 1'b0);
    endtask

    task automatic pop_expected(output int v);
        chk("exp_q_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) v = int'(exp_q.pop_front());
        else                  v = 0;
    endtask

    task automatic run_one(input int na, input int nb, input int nc);
        int v;
        drive(na, nb, nc);
        wait_done(0, 0);
        pop_expected(v);
        repeat (2) @(negedge clk);
        scan_check(v);
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int v;
        int ix;
        int nbusy;
        bit saw_busy;

        rst = 1'b1;
        a   = '0;
        b   = '0;
        cin = 1'b0;
        en  = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy1, 1'b0);

        run_one(123, 45, 1);
        run_one(255, 255, 1);
        run_one(3, 4, 0);

        // Operand change while shifting: first snapshot completes, then a second run.
        drive(10, 7, 0);
        wait_done(3, 20);
        pop_expected(v);
        repeat (2) @(negedge clk);
        check_active("mid_d4", v, D, {4'hF, dig1}, font1, ix);
        chk("mid_ovf", ovf1, 1'b0);
        wait_done(0, 0);
        pop_expected(v);
        repeat (2) @(negedge clk);
        scan_check(v);
        chk("exp_q_empty", exp_q.size(), 0);

        // Display disabled: outputs blank while the conversion still finishes.
        drive(50, 0, 0);
        en = 1'b0;
        saw_busy = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy1) saw_busy = 1'b1;
            chk("en_off_dig1", dig1, 4'hF);
            chk("en_off_font1", font1, 8'hFF);
            chk("en_off_dig2", dig2, 2'h3);
            chk("en_off_font2", font2, 8'hFF);
        end
        chk("en_off_conv", {saw_busy, busy1}, 2'b10);
        pop_expected(v);
        en = 1'b1;
        @(negedge clk);
        chk("en_first_dig1", dig1, 4'b1110);
        chk("en_first_dig2", dig2, 2'b10);
        scan_check(v);

        repeat (3) begin
            run_one($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
        end

        // Reset in the middle of SHIFT discards everything.
        drive(200, 0, 0);
        ix = 0;
        while (!busy1 && ix < 10) begin
            @(negedge clk);
            ix++;
        end
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", busy1, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        a   = '0;
        b   = '0;
        cin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nbusy = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy1) nbusy++;
        end
        chk("post_reset_busy", nbusy, 0);
        scan_check(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
